cp2_unit: RTL and testbench

- Coprocessor-2 attached to the cpu's coprocessor port. Consumes the instruction word broadcast from the ID stage and the EX-stage strobes: arithmetic start, transfer-to, transfer-from.
- Holds an 8x32 register file. Executes iterative 32-cycle MULU/DIVU and single-cycle ADD/SUB.
- Returns data, busy flags and exception reports to the cpu's MEM/ctrl stages.

---
 rtl/cp2_unit_pkg.sv | 47 ++++
 rtl/cp2_unit_if.sv | 32 +++
 rtl/cp2_unit_muldiv.sv | 68 ++++++
 rtl/cp2_unit.sv | 117 +++++++++++
 tb/tb_cp2_unit.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/cp2_unit_pkg.sv
// Shared definitions for the coprocessor-2 unit: sizes, funct/exception codes,
// FSM encodings and instruction-word field decoding.
package cp2_unit_pkg;

  localparam int NREG   = 8;
  localparam int REG_AW = $clog2(NREG);
  localparam int ITER   = 32;
  localparam int CNT_W  = $clog2(ITER);
  localparam int EXC_W  = 2;

  localparam logic [3:0] FUNCT_ADD  = 4'd0;
  localparam logic [3:0] FUNCT_SUB  = 4'd1;
  localparam logic [3:0] FUNCT_MULU = 4'd2;
  localparam logic [3:0] FUNCT_DIVU = 4'd3;

  localparam logic [EXC_W-1:0] CP2_EXC_NONE = 2'd0;
  localparam logic [EXC_W-1:0] CP2_EXC_DIVZ = 2'd1;
  localparam logic [EXC_W-1:0] CP2_EXC_ILL  = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int IR_FUNCT_LSB = 0;
  localparam int IR_RD_LSB    = 8;
  localparam int IR_RS_LSB    = 11;
  localparam int IR_RT_LSB    = 14;

  typedef logic [REG_AW-1:0] reg_idx_t;

  typedef struct packed {
    logic [3:0] funct;
    reg_idx_t   rd;
    reg_idx_t   rs;
    reg_idx_t   rt;
  } ir_fields_t;

  function automatic ir_fields_t decode_ir(input logic [31:0] ir);
    ir_fields_t f;
    f.funct = ir[IR_FUNCT_LSB +: 4];
    f.rd    = ir[IR_RD_LSB +: REG_AW];
    f.rs    = ir[IR_RS_LSB +: REG_AW];
    f.rt    = ir[IR_RT_LSB +: REG_AW];
    return f;
  endfunction

endpackage

// File: rtl/cp2_unit_if.sv
// Coprocessor port between the cpu pipeline (master) and coprocessor-2 (slave).
interface cp2_unit_if;

  logic                           cp_irenable;
  logic [31:0]                    cp_ir;
  logic                           cp2_as;
  logic                           cp2_ts;
  logic                           cp2_tds;
  logic [31:0]                    cp2_tdata;
  logic                           cp2_fs;
  logic                           cp2_fds;
  logic [31:0]                    cp2_fdata;
  logic                           cp2_abusy;
  logic                           cp2_tbusy;
  logic                           cp2_fbusy;
  logic                           cp2_excs;
  logic                           cp2_exc;
  logic [cp2_unit_pkg::EXC_W-1:0] cp2_exccode;

  modport master (
    output cp_irenable, cp_ir, cp2_as, cp2_ts, cp2_tds, cp2_tdata, cp2_fs,
    input  cp2_fds, cp2_fdata, cp2_abusy, cp2_tbusy, cp2_fbusy,
           cp2_excs, cp2_exc, cp2_exccode
  );

  modport slave (
    input  cp_irenable, cp_ir, cp2_as, cp2_ts, cp2_tds, cp2_tdata, cp2_fs,
    output cp2_fds, cp2_fdata, cp2_abusy, cp2_tbusy, cp2_fbusy,
           cp2_excs, cp2_exc, cp2_exccode
  );

endinterface

// File: rtl/cp2_unit_muldiv.sv
// Iterative unsigned multiplier (shift-add, low word) and restoring divider.
// One step per cycle for ITER cycles after start_i; done_o marks the last step.
module cp2_unit_muldiv
  import cp2_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        div_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        done_o,
  output logic [31:0] lo_o,
  output logic [31:0] hi_o
);

  logic             run_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      acc_q;   // product accumulator / partial remainder
  logic [31:0]      opb_q;   // multiplicand (shifted left) / divisor
  logic [31:0]      sh_q;    // multiplier (shifted right) / dividend->quotient
  logic [32:0]      shifted;
  logic [33:0]      diff;

  assign shifted = {acc_q, sh_q[31]};
  assign diff    = {1'b0, shifted} - {2'b00, opb_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q <= 1'b0;
      div_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
      opb_q <= '0;
      sh_q  <= '0;
    end else if (start_i) begin
      run_q <= 1'b1;
      div_q <= div_i;
      cnt_q <= CNT_W'(ITER - 1);
      acc_q <= '0;
      opb_q <= div_i ? b_i : a_i;
      sh_q  <= div_i ? a_i : b_i;
    end else if (run_q) begin
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) run_q <= 1'b0;
      if (div_q) begin
        // diff[33] set means the trial subtraction went negative: restore.
        if (!diff[33]) begin
          acc_q <= diff[31:0];
          sh_q  <= {sh_q[30:0], 1'b1};
        end else begin
          acc_q <= shifted[31:0];
          sh_q  <= {sh_q[30:0], 1'b0};
        end
      end else begin
        if (sh_q[0]) acc_q <= acc_q + opb_q;
        opb_q <= opb_q << 1;
        sh_q  <= sh_q >> 1;
      end
    end
  end

  assign done_o = run_q && (cnt_q == '0);
  assign lo_o   = div_q ? sh_q : acc_q;
  assign hi_o   = acc_q;

endmodule

// File: rtl/cp2_unit.sv
// Coprocessor-2: 8x32 register file, single-cycle ADD/SUB, iterative MULU/DIVU,
// cpu transfer-to/transfer-from paths and exception reporting.
module cp2_unit
  import cp2_unit_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  cp2_unit_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic [31:0]      ir_q;
  logic [31:0]      cr_q [NREG];
  reg_idx_t         dest_q;
  reg_idx_t         dest_hi;
  logic             div_q;
  logic             fds_q;
  logic [31:0]      fdata_q;
  logic             excs_q;
  logic [EXC_W-1:0] exccode_q;

  ir_fields_t  ir_f;
  logic        abusy, idle_as, is_addsub, is_muldiv, ill, divz;
  logic        tbusy, fbusy, md_start, md_done;
  logic [31:0] op_a, op_b, md_lo, md_hi;

  assign ir_f    = decode_ir(ir_q);
  assign op_a    = cr_q[ir_f.rs];
  assign op_b    = cr_q[ir_f.rt];
  assign abusy   = (state_q != ST_IDLE);
  assign idle_as = bus.cp2_as && !abusy;
  assign dest_hi = dest_q + reg_idx_t'(1);

  assign is_addsub = (ir_f.funct == FUNCT_ADD)  || (ir_f.funct == FUNCT_SUB);
  assign is_muldiv = (ir_f.funct == FUNCT_MULU) || (ir_f.funct == FUNCT_DIVU);
  assign ill       = !(is_addsub || is_muldiv);
  assign divz      = (ir_f.funct == FUNCT_DIVU) && (op_b == '0);
  assign md_start  = idle_as && is_muldiv && !divz;

  // A pending DIVU owns two destinations, rd and rd+1 (wrapping).
  assign tbusy = abusy && ((ir_f.rd == dest_q) || (div_q && (ir_f.rd == dest_hi)));
  assign fbusy = abusy && ((ir_f.rs == dest_q) || (div_q && (ir_f.rs == dest_hi)));

  cp2_unit_muldiv u_muldiv (
    .clk     (clk),
    .rst     (rst),
    .start_i (md_start),
    .div_i   (ir_f.funct == FUNCT_DIVU),
    .a_i     (op_a),
    .b_i     (op_b),
    .done_o  (md_done),
    .lo_o    (md_lo),
    .hi_o    (md_hi)
  );

  always_comb begin
    // NOTE: default assignment first so every path drives state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (md_start) state_d = ST_RUN;
      ST_RUN:  if (md_done)  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments throughout so every read in this block sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ir_q      <= '0;
      dest_q    <= '0;
      div_q     <= 1'b0;
      fds_q     <= 1'b0;
      fdata_q   <= '0;
      excs_q    <= 1'b0;
      exccode_q <= CP2_EXC_NONE;
      // NOTE: the register file is reset because software may read zeros out of it.
      for (int i = 0; i < NREG; i++) cr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (bus.cp_irenable) ir_q <= bus.cp_ir;

      fds_q <= bus.cp2_fs && !fbusy;
      if (bus.cp2_fs && !fbusy) fdata_q <= cr_q[ir_f.rs];

      excs_q <= idle_as && (ill || divz);
      if (idle_as && ill)       exccode_q <= CP2_EXC_ILL;
      else if (idle_as && divz) exccode_q <= CP2_EXC_DIVZ;
      else                      exccode_q <= CP2_EXC_NONE;

      if (md_start) begin
        dest_q <= ir_f.rd;
        div_q  <= (ir_f.funct == FUNCT_DIVU);
      end

      // Later writes take priority: transfer-to < writeback / ADD-SUB.
      if (bus.cp2_ts && bus.cp2_tds && !tbusy) cr_q[ir_f.rd] <= bus.cp2_tdata;
      if (state_q == ST_DONE) begin
        cr_q[dest_q] <= md_lo;
        if (div_q) cr_q[dest_hi] <= md_hi;
      end
      if (idle_as && is_addsub)
        cr_q[ir_f.rd] <= (ir_f.funct == FUNCT_SUB) ? op_a - op_b : op_a + op_b;
    end
  end

  assign bus.cp2_fds     = fds_q;
  assign bus.cp2_fdata   = fdata_q;
  assign bus.cp2_abusy   = abusy;
  assign bus.cp2_tbusy   = tbusy;
  assign bus.cp2_fbusy   = fbusy;
  assign bus.cp2_excs    = excs_q;
  assign bus.cp2_exc     = excs_q;
  assign bus.cp2_exccode = exccode_q;

endmodule

// File: tb/tb_cp2_unit.sv
// Directed scoreboard bench for cp2_unit: stimulus queues expected transfer-from
// data and exception reports; a negedge monitor compares whatever the DUT presents.
module tb_cp2_unit;
  import cp2_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec  = 0;
  int   n_fail = 0;

  logic [31:0] exp_fdata[$];
  logic [2:0]  exp_exc[$];   // {exc, exccode}

  cp2_unit_if bus ();

  cp2_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [3:0] funct, input int rd, input int rs,
                                        input int rt);
    logic [31:0] ir;
    ir = '0;
    ir[3:0]   = funct;
    ir[10:8]  = rd[2:0];
    ir[13:11] = rs[2:0];
    ir[16:14] = rt[2:0];
    return ir;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_ir(input logic [31:0] ir);
    bus.cp_irenable = 1'b1;
    bus.cp_ir       = ir;
    tick();
    bus.cp_irenable = 1'b0;
  endtask

  task automatic write_reg(input int rd, input logic [31:0] data);
    load_ir(mk_ir(FUNCT_ADD, rd, 0, 0));
    bus.cp2_ts = 1'b1; bus.cp2_tds = 1'b1; bus.cp2_tdata = data;
    tick();
    bus.cp2_ts = 1'b0; bus.cp2_tds = 1'b0;
  endtask

  task automatic read_reg(input int rs, input logic [31:0] exp);
    load_ir(mk_ir(FUNCT_ADD, 0, rs, 0));
    exp_fdata.push_back(exp);
    bus.cp2_fs = 1'b1;
    tick();
    bus.cp2_fs = 1'b0;
  endtask

  task automatic arith(input logic [3:0] funct, input int rd, input int rs, input int rt);
    load_ir(mk_ir(funct, rd, rs, rt));
    bus.cp2_as = 1'b1;
    tick();
    bus.cp2_as = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cp2_abusy) break;
    end
    check(name, {31'd0, bus.cp2_abusy}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_fds"},   {31'd0, bus.cp2_fds},   32'd0);
    check({tag, "_fdata"}, bus.cp2_fdata,          32'd0);
    check({tag, "_abusy"}, {31'd0, bus.cp2_abusy}, 32'd0);
    check({tag, "_tbusy"}, {31'd0, bus.cp2_tbusy}, 32'd0);
    check({tag, "_fbusy"}, {31'd0, bus.cp2_fbusy}, 32'd0);
    check({tag, "_excs"},  {31'd0, bus.cp2_excs},  32'd0);
    check({tag, "_exc"},   {29'd0, bus.cp2_exc, bus.cp2_exccode}, 32'd0);
  endtask

  // Monitor: every presented response must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.cp2_fds) begin
      if (exp_fdata.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL fds_unexpected: got fdata %h expected no strobe at %0t", bus.cp2_fdata, $time);
      end else begin
        check("fdata", bus.cp2_fdata, exp_fdata.pop_front());
      end
    end
    if (bus.cp2_excs) begin
      if (exp_exc.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL excs_unexpected: got code %0d expected no strobe at %0t", bus.cp2_exccode, $time);
      end else begin
        check("exc", {29'd0, bus.cp2_exc, bus.cp2_exccode}, {29'd0, exp_exc.pop_front()});
      end
    end
  end

  initial begin
    int busy_cnt;
    bus.cp_irenable = 1'b0; bus.cp_ir = '0; bus.cp2_as = 1'b0;
    bus.cp2_ts = 1'b0; bus.cp2_tds = 1'b0; bus.cp2_tdata = '0; bus.cp2_fs = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("rst");

    // Transfer-to then transfer-from.
    write_reg(1, 32'h7);
    write_reg(2, 32'h3);
    read_reg(1, 32'h7);
    read_reg(2, 32'h3);

    arith(FUNCT_ADD, 3, 1, 2);
    read_reg(3, 32'hA);

    // ADD and transfer-to hitting the same rd in one cycle: ADD wins.
    write_reg(1, 32'h0);
    write_reg(2, 32'h1);
    load_ir(mk_ir(FUNCT_ADD, 3, 1, 2));
    bus.cp2_as = 1'b1; bus.cp2_ts = 1'b1; bus.cp2_tds = 1'b1; bus.cp2_tdata = 32'h55;
    tick();
    bus.cp2_as = 1'b0; bus.cp2_ts = 1'b0; bus.cp2_tds = 1'b0;
    read_reg(3, 32'h1);
    arith(FUNCT_SUB, 3, 1, 2);
    read_reg(3, 32'hFFFF_FFFF);

    // MULU: busy for ITER+1 cycles, reads of the destination held off.
    write_reg(1, 32'hFFFF_FFFF);
    write_reg(2, 32'h2);
    arith(FUNCT_MULU, 6, 1, 2);
    busy_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!bus.cp2_abusy) break;
      busy_cnt++;
      if (i == 2) begin
        bus.cp_irenable = 1'b1; bus.cp_ir = mk_ir(FUNCT_ADD, 6, 6, 0);
      end else if (i == 3) begin
        bus.cp_irenable = 1'b0;
        check("mulu_fbusy", {31'd0, bus.cp2_fbusy}, 32'd1);
        check("mulu_tbusy", {31'd0, bus.cp2_tbusy}, 32'd1);
        bus.cp2_fs = 1'b1;
      end else if (i == 4) begin
        bus.cp2_fs = 1'b0;
      end
    end
    check("mulu_busy_cycles", busy_cnt, 33);
    read_reg(6, 32'hFFFF_FFFE);

    write_reg(1, 32'd100);
    write_reg(2, 32'd7);
    arith(FUNCT_DIVU, 4, 1, 2);
    wait_idle("divu_idle");
    read_reg(4, 32'd14);
    read_reg(5, 32'd2);

    // DIVU with rd=7: remainder wraps into cr0.
    write_reg(1, 32'd9);
    write_reg(2, 32'd4);
    arith(FUNCT_DIVU, 7, 1, 2);
    wait_idle("divu7_idle");
    read_reg(7, 32'd2);
    read_reg(0, 32'd1);

    // Divide by zero: exception, no writes, never busy.
    write_reg(2, 32'd0);
    exp_exc.push_back({1'b1, CP2_EXC_DIVZ});
    arith(FUNCT_DIVU, 4, 1, 2);
    @(negedge clk);
    check("divz_abusy", {31'd0, bus.cp2_abusy}, 32'd0);
    read_reg(4, 32'd14);
    read_reg(5, 32'd2);

    exp_exc.push_back({1'b1, CP2_EXC_ILL});
    arith(4'hF, 3, 1, 2);
    read_reg(3, 32'hFFFF_FFFF);

    // Transfer-from alongside a write to the same register returns the old value.
    load_ir(mk_ir(FUNCT_ADD, 3, 3, 0));
    exp_fdata.push_back(32'hFFFF_FFFF);
    bus.cp2_fs = 1'b1; bus.cp2_ts = 1'b1; bus.cp2_tds = 1'b1; bus.cp2_tdata = 32'h1234;
    tick();
    bus.cp2_fs = 1'b0; bus.cp2_ts = 1'b0; bus.cp2_tds = 1'b0;
    read_reg(3, 32'h1234);

    // Reset in the middle of a MULU.
    write_reg(1, 32'd5);
    write_reg(2, 32'd6);
    arith(FUNCT_MULU, 7, 1, 2);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("midrst");
    write_reg(2, 32'd5);
    write_reg(3, 32'd4);
    arith(FUNCT_MULU, 1, 2, 3);
    @(negedge clk);
    check("post_rst_abusy", {31'd0, bus.cp2_abusy}, 32'd1);
    wait_idle("post_rst_idle");
    read_reg(1, 32'd20);
    read_reg(7, 32'd0);

    repeat (4) @(negedge clk);
    check("sb_fdata_drained", exp_fdata.size(), 0);
    check("sb_exc_drained", exp_exc.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
